// File: rtl/digit_serial_adder_if.sv
`default_nettype none
// ============================================================================
// digit_serial_adder_if : digit-in / result-out handshake bundle
// Revision: 1.0
// ============================================================================
interface digit_serial_adder_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 2
);
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  logic [DIGIT_W-1:0]            digit_a;
  logic [DIGIT_W-1:0]            digit_b;
  logic                          in_valid;
  logic                          in_ready;
  logic                          flush;
  logic [NUM_DIGITS*DIGIT_W-1:0] out_sum;
  logic                          out_carry;
  logic [CNT_W-1:0]              out_ovf_count;
  logic                          out_valid;
  logic                          out_ready;

  modport master (
    output digit_a, digit_b, in_valid, flush, out_ready,
    input  in_ready, out_sum, out_carry, out_ovf_count, out_valid
  );

  modport slave (
    input  digit_a, digit_b, in_valid, flush, out_ready,
    output in_ready, out_sum, out_carry, out_ovf_count, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/digit_serial_adder.sv
`default_nettype none
// ============================================================================
// digit_serial_adder : LSB-first digit-serial adder with valid/ready result.
// Optional macro DIGIT_SERIAL_ADDER_SAT_EN saturates the sum on final carry.
// Revision: 1.0
// ============================================================================
module digit_serial_adder #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 2,
  parameter int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  digit_serial_adder_if.slave   bus
);

  localparam int SUM_W = NUM_DIGITS * DIGIT_W;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [SUM_W-1:0]   r_sum;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_valid;
  logic               r_in_ready;

  logic               w_accept;
  logic [DIGIT_W:0]   w_s;

  assign w_accept = bus.in_valid && r_in_ready && !bus.flush;
  assign w_s      = {1'b0, bus.digit_a} + {1'b0, bus.digit_b}
                  + {{DIGIT_W{1'b0}}, r_carry};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_sum      <= '0;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE, S_COLLECT: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cnt   <= '0;
          end else if (w_accept) begin
            // Constant slices keep the digit write free of variable part-selects.
            for (int k = 0; k < NUM_DIGITS; k++) begin
              if (r_idx == IDX_W'(k)) begin
                r_sum[k*DIGIT_W +: DIGIT_W] <= w_s[DIGIT_W-1:0];
              end
            end
            r_carry <= w_s[DIGIT_W];
            r_cnt   <= r_cnt + CNT_W'(w_s[DIGIT_W]);
            if (r_idx == LAST_IDX) begin
              r_state    <= S_HOLD;
              r_idx      <= '0;
              r_valid    <= 1'b1;
              r_in_ready <= 1'b0;
`ifdef DIGIT_SERIAL_ADDER_SAT_EN
              if (w_s[DIGIT_W]) begin
                r_sum <= '1;
              end
`endif
            end else begin
              r_state <= S_COLLECT;
              r_idx   <= r_idx + IDX_W'(1);
            end
          end
        end
        S_HOLD: begin
          // flush is deliberately ignored here: the result must drain first.
          if (bus.out_ready) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_sum      <= '0;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_idx      <= '0;
          r_carry    <= 1'b0;
          r_sum      <= '0;
          r_cnt      <= '0;
          r_valid    <= 1'b0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.out_sum       = r_sum;
  assign bus.out_carry     = r_carry;
  assign bus.out_ovf_count = r_cnt;
  assign bus.out_valid     = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
`default_nettype none
// ============================================================================
// tb_digit_serial_adder : table, corner-case and random checks vs arithmetic model
// Revision: 1.0
// ============================================================================
module tb_digit_serial_adder;
  localparam int ND = 4;
  localparam int DW = 2;
  localparam int SW = ND * DW;
  localparam int CW = $clog2(ND + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  digit_serial_adder_if #(.NUM_DIGITS(ND), .DIGIT_W(DW)) bus();

  digit_serial_adder #(.NUM_DIGITS(ND), .DIGIT_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] a;
    logic [SW-1:0] b;
    logic [SW-1:0] sum;
    logic          carry;
    int            cnt;
  } vec_t;

  vec_t tbl [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: whole-word addition; digit k overflows when the low (k+1) digits carry out.
  task automatic model(input logic [SW-1:0] a, input logic [SW-1:0] b,
                       output logic [SW-1:0] s, output logic c, output int cnt);
    longint full;
    longint m;
    full = longint'(a) + longint'(b);
    s    = full[SW-1:0];
    c    = full[SW];
    cnt  = 0;
    for (int k = 0; k < ND; k++) begin
      m = longint'(1) << (DW * (k + 1));
      if ((longint'(a) % m) + (longint'(b) % m) >= m) cnt++;
    end
`ifdef DIGIT_SERIAL_ADDER_SAT_EN
    if (c) s = '1;
`endif
  endtask

  task automatic feed(input logic [SW-1:0] a, input logic [SW-1:0] b,
                      input int lo, input int hi, input bit gaps);
    int t;
    for (int k = lo; k <= hi; k++) begin
      if (gaps) repeat ($urandom_range(0, 1)) step();
      bus.digit_a  = a[k*DW +: DW];
      bus.digit_b  = b[k*DW +: DW];
      bus.in_valid = 1'b1;
      t = 0;
      while (!bus.in_ready && t < 20) begin
        step();
        t++;
      end
      if (t >= 20) begin
        chk("in_ready_timeout", 0, 1);
        bus.in_valid = 1'b0;
        return;
      end
      step();
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic check_result(input logic [SW-1:0] es, input logic ec, input int ecnt);
    chk("out_valid", longint'(bus.out_valid), 1);
    chk("in_ready_hold", longint'(bus.in_ready), 0);
    chk("out_sum", longint'(bus.out_sum), longint'(es));
    chk("out_carry", longint'(bus.out_carry), longint'(ec));
    chk("out_ovf_count", longint'(bus.out_ovf_count), longint'(ecnt));
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("valid_drop", longint'(bus.out_valid), 0);
    chk("in_ready_back", longint'(bus.in_ready), 1);
    chk("sum_cleared", longint'(bus.out_sum), 0);
  endtask

  initial begin
    logic [SW-1:0] ra, rb, es;
    logic          ec;
    int            ecnt;

    tbl[0] = '{a: 8'h5B, b: 8'h27, sum: 8'h82, carry: 1'b0, cnt: 3};
`ifdef DIGIT_SERIAL_ADDER_SAT_EN
    tbl[1] = '{a: 8'hFF, b: 8'h01, sum: 8'hFF, carry: 1'b1, cnt: 4};
    tbl[2] = '{a: 8'hFF, b: 8'hFF, sum: 8'hFF, carry: 1'b1, cnt: 4};
`else
    tbl[1] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, carry: 1'b1, cnt: 4};
    tbl[2] = '{a: 8'hFF, b: 8'hFF, sum: 8'hFE, carry: 1'b1, cnt: 4};
`endif
    tbl[3] = '{a: 8'h10, b: 8'h30, sum: 8'h40, carry: 1'b0, cnt: 1};
    tbl[4] = '{a: 8'h01, b: 8'h01, sum: 8'h02, carry: 1'b0, cnt: 0};
    tbl[5] = '{a: 8'hAA, b: 8'h55, sum: 8'hFF, carry: 1'b0, cnt: 0};
    tbl[6] = '{a: 8'h00, b: 8'h00, sum: 8'h00, carry: 1'b0, cnt: 0};

    bus.digit_a   = '0;
    bus.digit_b   = '0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    chk("rst_valid", longint'(bus.out_valid), 0);
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    chk("rst_sum", longint'(bus.out_sum), 0);
    chk("rst_carry", longint'(bus.out_carry), 0);
    chk("rst_cnt", longint'(bus.out_ovf_count), 0);

    // Table: result must not appear before the last digit, then appear one cycle after it.
    for (int i = 0; i < 7; i++) begin
      feed(tbl[i].a, tbl[i].b, 0, ND - 2, 1'b0);
      chk("early_valid", longint'(bus.out_valid), 0);
      feed(tbl[i].a, tbl[i].b, ND - 1, ND - 1, 1'b0);
      check_result(tbl[i].sum, tbl[i].carry, tbl[i].cnt);
      handshake();
    end

    // Backpressure with a pending input digit.
    feed(8'h5B, 8'h27, 0, ND - 1, 1'b0);
    bus.digit_a  = 2'd1;
    bus.digit_b  = 2'd1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_in_ready", longint'(bus.in_ready), 0);
      check_result(8'h82, 1'b0, 3);
    end
    bus.in_valid = 1'b0;
    handshake();

    // Flush mid-operation together with in_valid drops the digit.
    feed(8'hFF, 8'hFF, 0, 1, 1'b0);
    chk("partial_sum", longint'(bus.out_sum), 8'h0E);
    chk("partial_cnt", longint'(bus.out_ovf_count), 2);
    bus.digit_a  = 2'd3;
    bus.digit_b  = 2'd3;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_sum", longint'(bus.out_sum), 0);
    chk("flush_cnt", longint'(bus.out_ovf_count), 0);
    chk("flush_in_ready", longint'(bus.in_ready), 1);
    feed(8'h01, 8'h01, 0, ND - 1, 1'b0);
    check_result(8'h02, 1'b0, 0);
    handshake();

    // Flush during HOLD is ignored.
    feed(8'h5B, 8'h27, 0, ND - 1, 1'b0);
    bus.flush = 1'b1;
    step();
    step();
    bus.flush = 1'b0;
    check_result(8'h82, 1'b0, 3);
    handshake();

    // Reset after the third digit.
    feed(8'h10, 8'h30, 0, 2, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_valid", longint'(bus.out_valid), 0);
    chk("mid_rst_in_ready", longint'(bus.in_ready), 1);
    chk("mid_rst_cnt", longint'(bus.out_ovf_count), 0);
    chk("mid_rst_sum", longint'(bus.out_sum), 0);
    feed(8'h10, 8'h30, 0, ND - 1, 1'b0);
    check_result(8'h40, 1'b0, 1);
    handshake();

    // Random operands with input gaps and output stalls.
    for (int i = 0; i < 30; i++) begin
      ra = SW'($urandom);
      rb = SW'($urandom);
      model(ra, rb, es, ec, ecnt);
      feed(ra, rb, 0, ND - 1, 1'b1);
      repeat ($urandom_range(0, 3)) step();
      check_result(es, ec, ecnt);
      handshake();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
